stream_mux_rr: RTL

Parametrised N-channel stream multiplexer with valid/ready handshakes, a registered output stage and round-robin or forced channel selection. It succeeds the team's combinational 4-bit 2:1 mux. It sits between several producer streams and a single consumer, and is arbitrated either fairly or under software control.

---
 rtl/stream_mux_rr.sv | 133 +++++++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with a registered output
// stage and round-robin or forced channel selection.
// Optional packet lock: define STREAM_MUX_LAST_LOCK_EN.
module stream_mux_rr #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    localparam int SELW = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH-1:0]       in_last,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic             load_en;
    logic             xfer;
    logic             found;
    logic             hi_found;
    logic             lo_found;
    logic [SELW-1:0]  hi_idx;
    logic [SELW-1:0]  lo_idx;
    logic [SELW-1:0]  g_idx;
    logic [SELW-1:0]  ptr;
    logic [NCH-1:0]   grant;
    logic [WIDTH-1:0] g_data;
    logic             g_last;
    logic             lock;
    logic [SELW-1:0]  lock_ch;

    assign load_en = rst_n && (!out_valid || out_ready);

    // Round-robin candidates: lowest valid at/above ptr, else lowest overall
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = SELW'(i);
                if (SELW'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = SELW'(i);
                end
            end
        end
    end

    // Pick the granted channel: lock owner, forced sel, or round-robin
    always_comb begin
        found = 1'b0;
        g_idx = '0;
        if (lock) begin
            g_idx = lock_ch;
            for (int i = 0; i < NCH; i++) begin
                if (lock_ch == SELW'(i) && in_valid[i]) found = 1'b1;
            end
        end else if (mode) begin
            g_idx = sel;
            for (int i = 0; i < NCH; i++) begin
                if (sel == SELW'(i) && in_valid[i]) found = 1'b1;
            end
        end else begin
            found = hi_found || lo_found;
            g_idx = hi_found ? hi_idx : lo_idx;
        end
    end

    // One-hot grant and the granted channel's payload
    always_comb begin
        grant  = '0;
        g_data = '0;
        g_last = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (found && g_idx == SELW'(i)) begin
                grant[i] = 1'b1;
                g_data   = in_data[i*WIDTH +: WIDTH];
                g_last   = in_last[i];
            end
        end
    end

    assign in_ready = load_en ? grant : '0;
    assign xfer     = load_en && found;

`ifdef STREAM_MUX_LAST_LOCK_EN
    // Packet lock: held from a non-last beat until that channel's last beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock    <= 1'b0;
            lock_ch <= '0;
        end else if (xfer) begin
            lock    <= !g_last;
            lock_ch <= g_idx;
        end
    end
`else
    assign lock    = 1'b0;
    assign lock_ch = '0;
`endif

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (load_en) out_valid <= xfer;
            if (xfer) begin
                out_data <= g_data;
                out_last <= g_last;
                out_ch   <= g_idx;
                if (!mode) begin
                    ptr <= (int'(g_idx) == NCH - 1) ? '0 : g_idx + 1'b1;
                end
            end
        end
    end

endmodule
